// File: rtl/rggen_adapter_common_ex_if.sv
// Shared types and the two bus interfaces used by rggen_adapter_common_ex.
//   rggen_rtl_pkg     : access / status encodings
//   rggen_bus_if      : host-side request/response bus (master/slave modports)
//   rggen_register_if : register-side request/response (host/register modports)
package rggen_rtl_pkg;
    typedef logic [1:0] rggen_access;
    typedef logic [1:0] rggen_status;

    localparam rggen_access RGGEN_READ  = 2'b10;
    localparam rggen_access RGGEN_WRITE = 2'b11;

    localparam rggen_status RGGEN_OKAY         = 2'b00;
    localparam rggen_status RGGEN_EXOKAY       = 2'b01;
    localparam rggen_status RGGEN_SLAVE_ERROR  = 2'b10;
    localparam rggen_status RGGEN_DECODE_ERROR = 2'b11;
endpackage

interface rggen_bus_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                       valid;
    rggen_access                access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       ready;
    rggen_status                status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport master (
        output valid, access, address, write_data, strobe,
        input  ready, status, read_data
    );

    modport slave (
        input  valid, access, address, write_data, strobe,
        output ready, status, read_data
    );
endinterface

interface rggen_register_if #(
    parameter int ADDRESS_WIDTH = 8,
    parameter int BUS_WIDTH     = 32
);
    import rggen_rtl_pkg::*;

    logic                       valid;
    rggen_access                access;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH-1:0]       write_data;
    logic [BUS_WIDTH/8-1:0]     strobe;
    logic                       active;
    logic                       ready;
    rggen_status                status;
    logic [BUS_WIDTH-1:0]       read_data;

    modport host (
        output valid, access, address, write_data, strobe,
        input  active, ready, status, read_data
    );

    modport register (
        input  valid, access, address, write_data, strobe,
        output active, ready, status, read_data
    );
endinterface

// File: rtl/rggen_adapter_common_ex.sv
// Common bus-to-register adapter: decodes the host window, fans a request out
// to every register entry, muxes the one-hot response back, and optionally
// adds a registered response stage and a BUSY watchdog.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset
//   bus_if       host-side bus (slave)
//   register_if  REGISTERS register-side request/response entries (host)
//   o_timeout    registered one-cycle pulse, the cycle after the watchdog fires
module rggen_adapter_common_ex
    import rggen_rtl_pkg::*;
#(
    parameter int                       ADDRESS_WIDTH       = 8,
    parameter int                       LOCAL_ADDRESS_WIDTH = 8,
    parameter int                       BUS_WIDTH           = 32,
    parameter int                       REGISTERS           = 1,
    parameter bit                       PRE_DECODE          = 1'b0,
    parameter bit [ADDRESS_WIDTH-1:0]   BASE_ADDRESS        = '0,
    parameter int                       BYTE_SIZE           = 256,
    parameter bit                       ERROR_STATUS        = 1'b0,
    parameter bit [BUS_WIDTH-1:0]       DEFAULT_READ_DATA   = '0,
    parameter bit                       RESPONSE_SLICE      = 1'b0,
    parameter int                       TIMEOUT_CYCLES      = 0
)(
    input  logic            i_clk,
    input  logic            i_rst_n,
    rggen_bus_if.slave      bus_if,
    rggen_register_if.host  register_if[REGISTERS],
    output logic            o_timeout
);
    localparam int COUNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam rggen_status DEFAULT_STATUS = ERROR_STATUS ? RGGEN_SLAVE_ERROR : RGGEN_OKAY;
    // Window end wraps within the address width when base + size overflows.
    localparam bit [ADDRESS_WIDTH-1:0] END_ADDRESS = BASE_ADDRESS + ADDRESS_WIDTH'(BYTE_SIZE - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        BUSY    = 2'b01,
        RESPOND = 2'b10
    } state_e;

    state_e                 state_r;
    logic [COUNT_WIDTH-1:0] count_r;
    logic                   timeout_r;
    rggen_status            slice_status_r;
    logic [BUS_WIDTH-1:0]   slice_read_data_r;

    logic                   inside_range_s;
    logic                   request_s;
    logic                   live_s;
    logic                   inactive_s;
    logic                   reg_done_s;
    logic                   default_done_s;
    logic                   timeout_s;
    logic                   done_s;
    logic [COUNT_WIDTH-1:0] busy_count_s;
    logic [REGISTERS-1:0]   active_s;
    logic [REGISTERS-1:0]   ready_s;
    rggen_status            reg_status_s [REGISTERS];
    logic [BUS_WIDTH-1:0]   reg_read_data_s [REGISTERS];
    rggen_status            sel_status_s;
    logic [BUS_WIDTH-1:0]   sel_read_data_s;
    rggen_status            resp_status_s;
    logic [BUS_WIDTH-1:0]   resp_read_data_s;

    // Window decode; the leading 1 keeps the lower-bound compare meaningful for a zero base.
    always_comb begin
        if (PRE_DECODE) begin
            inside_range_s = ({1'b1, bus_if.address} >= {1'b1, BASE_ADDRESS}) &&
                             (bus_if.address <= END_ADDRESS);
        end else begin
            inside_range_s = 1'b1;
        end
    end

    // A transfer is only "live" in the IDLE-valid cycle or in BUSY; anything the
    // registers report outside those cycles (e.g. after a timeout) is dropped.
    assign live_s    = i_rst_n && (((state_r == IDLE) && bus_if.valid) || (state_r == BUSY));
    assign request_s = i_rst_n && (state_r == IDLE) && bus_if.valid && inside_range_s;

    // Request fan-out and response collection per register entry.
    for (genvar i = 0; i < REGISTERS; i++) begin : g_register
        assign register_if[i].valid      = request_s;
        assign register_if[i].access     = bus_if.access;
        assign register_if[i].address    = bus_if.address[LOCAL_ADDRESS_WIDTH-1:0];
        assign register_if[i].write_data = bus_if.write_data;
        assign register_if[i].strobe     = bus_if.strobe;
        assign active_s[i]               = register_if[i].active;
        assign ready_s[i]                = register_if[i].ready;
        assign reg_status_s[i]           = register_if[i].status;
        assign reg_read_data_s[i]        = register_if[i].read_data;
    end

    // One-hot response mux over the active entries.
    always_comb begin
        sel_status_s    = RGGEN_OKAY;
        sel_read_data_s = '0;
        for (int i = 0; i < REGISTERS; i++) begin
            sel_status_s    = sel_status_s    | (reg_status_s[i]    & {2{active_s[i]}});
            sel_read_data_s = sel_read_data_s | (reg_read_data_s[i] & {BUS_WIDTH{active_s[i]}});
        end
    end

    assign inactive_s     = !inside_range_s || (active_s == '0);
    assign reg_done_s     = live_s && !inactive_s && (ready_s != '0);
    assign default_done_s = live_s && inactive_s;
    assign busy_count_s   = count_r + COUNT_WIDTH'(1);

    // Watchdog: fires in the N-th BUSY cycle unless a completion wins that cycle.
    always_comb begin
        if ((TIMEOUT_CYCLES > 0) && (state_r == BUSY) && !reg_done_s && !default_done_s) begin
            timeout_s = (busy_count_s == COUNT_WIDTH'(TIMEOUT_CYCLES));
        end else begin
            timeout_s = 1'b0;
        end
    end

    assign done_s = reg_done_s || default_done_s || timeout_s;

    // Response selection: register answer, default answer, or timeout error.
    always_comb begin
        if (reg_done_s) begin
            resp_status_s    = sel_status_s;
            resp_read_data_s = sel_read_data_s;
        end else if (default_done_s) begin
            resp_status_s    = DEFAULT_STATUS;
            resp_read_data_s = DEFAULT_READ_DATA;
        end else begin
            resp_status_s    = RGGEN_SLAVE_ERROR;
            resp_read_data_s = DEFAULT_READ_DATA;
        end
    end

    // Transfer sequencer: state, watchdog counter, response slice and timeout pulse.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_r           <= IDLE;
            count_r           <= '0;
            timeout_r         <= 1'b0;
            slice_status_r    <= RGGEN_OKAY;
            slice_read_data_r <= '0;
        end else begin
            timeout_r <= timeout_s;
            if (RESPONSE_SLICE && done_s) begin
                slice_status_r    <= resp_status_s;
                slice_read_data_r <= resp_read_data_s;
            end
            case (state_r)
                IDLE: begin
                    count_r <= '0;
                    if (done_s) begin
                        state_r <= RESPONSE_SLICE ? RESPOND : IDLE;
                    end else if (request_s) begin
                        state_r <= BUSY;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (TIMEOUT_CYCLES > 0) begin
                        count_r <= busy_count_s;
                    end else begin
                        count_r <= '0;
                    end
                    if (done_s) begin
                        state_r <= RESPONSE_SLICE ? RESPOND : IDLE;
                    end else begin
                        state_r <= BUSY;
                    end
                end
                RESPOND: begin
                    count_r <= '0;
                    state_r <= IDLE;
                end
                default: begin
                    count_r <= '0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign bus_if.ready     = RESPONSE_SLICE ? (state_r == RESPOND) : done_s;
    assign bus_if.status    = RESPONSE_SLICE ? slice_status_r    : resp_status_s;
    assign bus_if.read_data = RESPONSE_SLICE ? slice_read_data_r : resp_read_data_s;
    assign o_timeout        = timeout_r;

endmodule
